// File: rtl/riscv_muldiv.sv
// RV32M multiply/divide unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on a shared 64-bit accumulator.
// Latency: done seen at the 34th edge after the accepting edge; divide-by-zero and signed overflow at the 1st.
// Backpressure: start is taken only in IDLE; busy holds the controller off while CALC or DONE.
module riscv_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_funct3;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [5:0]  r_cnt;
  logic        r_init;      // first CALC cycle loads magnitudes instead of iterating
  logic [63:0] r_acc;       // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [31:0] r_b_mag;     // multiplicand / divisor magnitude
  logic        r_neg_q;     // negate product or quotient
  logic        r_neg_r;     // negate remainder
  logic [31:0] r_result;
  logic [4:0]  r_rd_out;

  // Request decode on the live inputs (fast paths are chosen at accept time)
  logic        w_in_div0;
  logic        w_in_ovf;
  logic [31:0] w_fast_result;
  assign w_in_div0     = funct3[2] && (op_b == 32'd0);
  assign w_in_ovf      = funct3[2] && !funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign w_fast_result = w_in_div0 ? (funct3[1] ? op_a : 32'hFFFF_FFFF)
                                   : (funct3[1] ? 32'd0 : 32'h8000_0000);

  // Operand signedness and magnitudes from the captured request
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  assign w_a_signed = (r_funct3 == 3'b001) || (r_funct3 == 3'b010) ||
                      (r_funct3 == 3'b100) || (r_funct3 == 3'b110);
  assign w_b_signed = (r_funct3 == 3'b001) || (r_funct3 == 3'b100) || (r_funct3 == 3'b110);
  assign w_a_neg    = w_a_signed && r_op_a[31];
  assign w_b_neg    = w_b_signed && r_op_b[31];
  assign w_a_mag    = w_a_neg ? (~r_op_a + 32'd1) : r_op_a;
  assign w_b_mag    = w_b_neg ? (~r_op_b + 32'd1) : r_op_b;

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_nxt;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [63:0] w_div_nxt;
  logic [63:0] w_acc_nxt;
  assign w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b_mag} : 33'd0);
  assign w_mul_nxt   = {w_mul_sum, r_acc[31:1]};
  assign w_div_shift = {r_acc[63:32], r_acc[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b_mag});
  // When the subtract succeeds the difference is below the divisor, so 32 bits hold it
  assign w_div_sub   = w_div_shift[31:0] - r_b_mag;
  assign w_div_nxt   = w_div_ge ? {w_div_sub, r_acc[30:0], 1'b1}
                                : {w_div_shift[31:0], r_acc[30:0], 1'b0};
  assign w_acc_nxt   = r_funct3[2] ? w_div_nxt : w_mul_nxt;

  // Sign fix-up and selection applied to the output of the last step
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_final;
  assign w_prod  = r_neg_q ? (~w_mul_nxt + 64'd1) : w_mul_nxt;
  assign w_quot  = r_neg_q ? (~w_div_nxt[31:0] + 32'd1) : w_div_nxt[31:0];
  assign w_rem   = r_neg_r ? (~w_div_nxt[63:32] + 32'd1) : w_div_nxt[63:32];
  assign w_final = r_funct3[2] ? (r_funct3[1] ? w_rem : w_quot)
                               : ((r_funct3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32]);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (w_in_div0 || w_in_ovf) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (!r_init && (r_cnt == 6'd31)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, iteration datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_funct3 <= 3'd0;
      r_op_a   <= 32'd0;
      r_op_b   <= 32'd0;
      r_cnt    <= 6'd0;
      r_init   <= 1'b0;
      r_acc    <= 64'd0;
      r_b_mag  <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= 32'd0;
      r_rd_out <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_funct3 <= funct3;
            r_op_a   <= op_a;
            r_op_b   <= op_b;
            r_rd_out <= rd_in;
            r_cnt    <= 6'd0;
            r_init   <= 1'b1;
            r_acc    <= 64'd0;
            if (w_in_div0 || w_in_ovf) r_result <= w_fast_result;
          end
        end
        S_CALC: begin
          if (r_init) begin
            r_init  <= 1'b0;
            r_acc   <= {32'd0, w_a_mag};
            r_b_mag <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
          end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) r_result <= w_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed bench for riscv_muldiv: hand-computed results, done latency and reset behaviour.
// Edge numbering: the accepting posedge is edge 0; done "at edge k" means seen high just before edge k.
// Inputs are driven and outputs sampled on the falling edge.
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;

  riscv_muldiv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called just after a falling edge with the unit idle; returns just after a falling edge.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start  = 1'b0;
      op_a   = ~a;
      op_b   = ~b;
      funct3 = ~f;
      rd_in  = ~rd;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    chk({tag, ".busy_in_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, ".result_hold"}, result, exp_res);
  endtask

  initial begin
    int n_done;
    int first_k, second_k;
    logic [31:0] r1, r2;
    logic [4:0]  rd1, rd2;

    rst = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    repeat (3) @(negedge clk);
    chk("reset.busy",   {31'd0, busy}, 32'd0);
    chk("reset.done",   {31'd0, done}, 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.rd_out", {27'd0, rd_out}, 32'd0);
    rst = 1'b0;

    // Accepted on the first posedge after reset release
    run_op("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 34);
    run_op("mulh",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 34);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 34);
    run_op("div",      3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 34);
    run_op("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 34);
    run_op("div_nb",   3'b100, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 34);
    run_op("rem_nb",   3'b110, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'd1,         34);
    run_op("divu",     3'b101, 32'd100,       32'd7,         5'd13, 32'd14,        34);
    run_op("remu",     3'b111, 32'd100,       32'd7,         5'd14, 32'd2,         34);
    run_op("divu_max", 3'b101, 32'hFFFF_FFFF, 32'd1,         5'd15, 32'hFFFF_FFFF, 34);
    run_op("div0",     3'b100, 32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 1);
    run_op("rem0",     3'b110, 32'd5,         32'd0,         5'd17, 32'd5,         1);
    run_op("divu0",    3'b101, 32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF, 1);
    run_op("remu0",    3'b111, 32'd5,         32'd0,         5'd19, 32'd5,         1);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'd0,         1);

    // Reset in the middle of a DIVU
    funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd22; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("midrst.busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst.busy",   {31'd0, busy}, 32'd0);
    chk("midrst.done",   {31'd0, done}, 32'd0);
    chk("midrst.result", result, 32'd0);
    chk("midrst.rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst.no_done", n_done, 0);
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 5'd23, 32'd12, 34);

    // start held high across a whole operation and beyond
    funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd3; start = 1'b1;
    @(posedge clk);
    first_k = 0; second_k = 0; r1 = '0; r2 = '0; rd1 = '0; rd2 = '0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (k == 1) begin
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9;
      end
      if (k == 36) start = 1'b0;
      if (done) begin
        if (first_k == 0) begin
          first_k = k; r1 = result; rd1 = rd_out;
        end else if (second_k == 0) begin
          second_k = k; r2 = result; rd2 = rd_out;
        end
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("held.first_edge",  first_k, 34);
    chk("held.first_res",   r1, 32'd42);
    chk("held.first_rd",    {27'd0, rd1}, 32'd3);
    chk("held.second_edge", second_k, 69);
    chk("held.second_res",  r2, 32'd14);
    chk("held.second_rd",   {27'd0, rd2}, 32'd9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_muldiv.md
RISCV_MULDIV -- requirements
Module: riscv_muldiv

Interface
REQ-001 SHALL have no parameters; the datapath is fixed at 32 bits.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request strobe from the controller for an M-extension operation.
REQ-005 SHALL have port funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port op_a  input  32  rs1 operand, taken from register-file read port reg_data_rs1.
REQ-007 SHALL have port op_b  input  32  rs2 operand, taken from register-file read port reg_data_rs2.
REQ-008 SHALL have port rd_in  input  5  destination register index of the request.
REQ-009 SHALL have port busy  output  1  high while an accepted operation is in flight; the controller stalls fetch on it.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result and rd_out are valid; the controller drives reg_write_en from it.
REQ-011 SHALL have port result  output  32  operation result, fed to the register-file write data path data_to_reg.
REQ-012 SHALL have port rd_out  output  5  captured rd_in, presented alongside result.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 SHALL accept a request only in IDLE with start=1: capture funct3, op_a, op_b and rd_in on that edge.
REQ-015 SHALL ignore start in CALC and DONE; captured operands SHALL NOT change.
REQ-016 SHALL assert busy exactly while the state is CALC or DONE.
REQ-017 SHALL perform normal operations in CALC by exactly 32 iterations, one per cycle: radix-2 shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-018 SHALL then enter DONE, assert done for one cycle, and return to IDLE.
REQ-019 SHALL assert done on the 34th posedge after the accepting edge, counting the accepting edge as edge 0.
REQ-020 SHALL select operand signedness per operation: MULH/DIV/REM treat both operands as signed; MULHSU treats op_a as signed and op_b as unsigned; MULHU/DIVU/REMU treat both as unsigned; MUL is sign-agnostic.
REQ-021 SHALL form the 64-bit product and return bits[31:0] for MUL and bits[63:32] for MULH/MULHSU/MULHU.
REQ-022 SHALL negate the product when exactly one signed-interpreted operand is negative.
REQ-023 SHALL give the quotient sign as sign(op_a) XOR sign(op_b) and the remainder the sign of op_a (truncating division).
REQ-024 SHALL treat divide by zero (op_b=0, funct3 1xx) as a fast path, going IDLE->DONE in one edge: DIV/DIVU result 32'hFFFF_FFFF; REM/REMU result = op_a.
REQ-025 SHALL treat signed overflow (DIV/REM with op_a=32'h8000_0000, op_b=32'hFFFF_FFFF) as a fast path: DIV result 32'h8000_0000; REM result 0.
REQ-026 SHALL hold result and rd_out stable after done until the next accepted request.
REQ-027 SHALL allow start in the cycle immediately after done (state IDLE), giving back-to-back operations.
REQ-028 SHALL use a 6-bit iteration counter that never wraps: the CALC->DONE transition occurs on count 31.

Reset
REQ-029 SHALL, on rst high at any time including mid-CALC, asynchronously force state IDLE and set busy=0, done=0, result=0, rd_out=0, counter=0 and all internal accumulators to 0.
REQ-030 SHALL discard any in-flight operation on reset, with no done pulse for it.
REQ-031 SHALL accept start on the first posedge after rst deasserts.

Verification
REQ-032 SHALL be verified by: MUL op_a=7, op_b=-3 (32'hFFFF_FFFD) -> done at edge 34 with result=32'hFFFF_FFEB, rd_out=rd_in.
REQ-033 SHALL be verified by: MULHU op_a=op_b=32'hFFFF_FFFF -> result=32'hFFFF_FFFE; MULH with the same operands -> result=0; MULHSU op_a=-1, op_b=2 -> result=32'hFFFF_FFFF.
REQ-034 SHALL be verified by: DIV -7/2 -> result=-3 (32'hFFFF_FFFD); REM -7/2 -> result=-1; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 SHALL be verified by: DIV 5/0 -> done one edge after start with result=32'hFFFF_FFFF; REM 5/0 -> result=5; DIV 32'h8000_0000/-1 -> result=32'h8000_0000.
REQ-036 SHALL be verified by: rst pulsed at edge 10 of a DIVU -> busy=0 and done=0 immediately; no done follows; a new MUL 3*4 started after reset -> result=12.
REQ-037 SHALL be verified by: start held high through a full operation -> only the first request is accepted; a second request is accepted on the edge after done, and its done follows 34 edges later.
